// File: rtl/css_mcu0_el2_pkg.sv
// css_mcu0_el2_pkg: shared types for the EL2 DCCM arbiter
package css_mcu0_el2_pkg;

  typedef enum logic {DCCM_ARB_INIT, DCCM_ARB_ARB} el2_dccm_arb_state_t;

  typedef struct packed {
    logic valid;
    logic is_dma;
  } el2_dccm_rd_src_t;

endpackage

// File: rtl/css_mcu0_el2_dccm_starve_cnt.sv
// css_mcu0_el2_dccm_starve_cnt: saturating DMA wait counter, flags when DMA must win
module css_mcu0_el2_dccm_starve_cnt #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic gnt_i,
  output logic at_max_o
);
  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // clear on grant, count waiting cycles up to MAX, hold when idle
  always_comb cnt_d = gnt_i ? '0 : (req_i && cnt_q != MAX_V) ? cnt_q + 1'b1 : cnt_q;

  // counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;

  assign at_max_o = cnt_q == MAX_V;
endmodule

// File: rtl/css_mcu0_el2_dccm_arb.sv
// css_mcu0_el2_dccm_arb: DCCM init sweep (CSS_MCU0_EL2_DCCM_INIT_EN), LSU/DMA arbitration, read return routing
module css_mcu0_el2_dccm_arb
  import css_mcu0_el2_pkg::*;
#(
  parameter int DCCM_BITS = 16,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter int DMA_STARVE_MAX = 15,
  parameter logic [DCCM_FDATA_WIDTH-1:0] INIT_FDATA = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lsu_req_i,
  input  logic                        lsu_we_i,
  input  logic [DCCM_BITS-1:0]        lsu_addr_lo_i,
  input  logic [DCCM_BITS-1:0]        lsu_addr_hi_i,
  input  logic [DCCM_FDATA_WIDTH-1:0] lsu_wdata_lo_i,
  input  logic [DCCM_FDATA_WIDTH-1:0] lsu_wdata_hi_i,
  output logic                        lsu_gnt_o,
  output logic                        lsu_rvalid_o,
  output logic [DCCM_FDATA_WIDTH-1:0] lsu_rdata_lo_o,
  output logic [DCCM_FDATA_WIDTH-1:0] lsu_rdata_hi_o,
  input  logic                        dma_req_i,
  input  logic                        dma_we_i,
  input  logic [DCCM_BITS-1:0]        dma_addr_i,
  input  logic [DCCM_FDATA_WIDTH-1:0] dma_wdata_i,
  output logic                        dma_gnt_o,
  output logic                        dma_rvalid_o,
  output logic [DCCM_FDATA_WIDTH-1:0] dma_rdata_o,
  output logic                        dccm_wren_o,
  output logic                        dccm_rden_o,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo_o,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi_o,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo_o,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi_o,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo_o,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi_o,
  input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo_i,
  input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi_i,
  output logic                        init_done_o
);
  el2_dccm_arb_state_t state_q, state_d;
  el2_dccm_rd_src_t    rd_src_q, rd_src_d;
  logic                sweep_last, in_init, arb, dma_force;
  logic [DCCM_BITS-1:0] init_addr;

`ifdef CSS_MCU0_EL2_DCCM_INIT_EN
  localparam el2_dccm_arb_state_t RST_ST = DCCM_ARB_INIT;
  logic [DCCM_BITS-3:0] idx_q, idx_d;
  // sweep index advances once per INIT cycle
  always_comb idx_d = in_init ? idx_q + 1'b1 : idx_q;
  // sweep index register
  always_ff @(posedge clk or posedge rst)
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  assign sweep_last = &idx_q;
  assign init_addr  = {idx_q, 2'b00};
`else
  localparam el2_dccm_arb_state_t RST_ST = DCCM_ARB_ARB;
  assign sweep_last = 1'b0;
  assign init_addr  = '0;
`endif

  // leave INIT once the last sweep word is written
  always_comb state_d = (in_init && sweep_last) ? DCCM_ARB_ARB : state_q;

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= RST_ST;
    else     state_q <= state_d;

  assign in_init     = state_q == DCCM_ARB_INIT;
  assign arb         = !in_init && !rst;
  assign init_done_o = arb;

  css_mcu0_el2_dccm_starve_cnt #(.MAX(DMA_STARVE_MAX)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .req_i    (dma_req_i),
    .gnt_i    (dma_gnt_o),
    .at_max_o (dma_force)
  );

  assign lsu_gnt_o = arb && lsu_req_i && !(dma_force && dma_req_i);
  assign dma_gnt_o = arb && dma_req_i && (dma_force || !lsu_req_i);

  assign dccm_wren_o = in_init || (lsu_gnt_o && lsu_we_i) || (dma_gnt_o && dma_we_i);
  assign dccm_rden_o = (lsu_gnt_o && !lsu_we_i) || (dma_gnt_o && !dma_we_i);

  assign dccm_wr_addr_lo_o = in_init ? init_addr : dma_gnt_o ? dma_addr_i : lsu_addr_lo_i;
  assign dccm_wr_addr_hi_o = in_init ? init_addr : dma_gnt_o ? dma_addr_i : lsu_addr_hi_i;
  assign dccm_wr_data_lo_o = in_init ? INIT_FDATA : dma_gnt_o ? dma_wdata_i : lsu_wdata_lo_i;
  assign dccm_wr_data_hi_o = in_init ? INIT_FDATA : dma_gnt_o ? dma_wdata_i : lsu_wdata_hi_i;
  assign dccm_rd_addr_lo_o = dma_gnt_o ? dma_addr_i : lsu_addr_lo_i;
  assign dccm_rd_addr_hi_o = dma_gnt_o ? dma_addr_i : lsu_addr_hi_i;

  // remember who issued the read so the returning data is steered next cycle
  always_comb rd_src_d = '{valid: dccm_rden_o, is_dma: dma_gnt_o};

  // read-source register
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_src_q <= '0;
    else     rd_src_q <= rd_src_d;

  assign lsu_rvalid_o   = rd_src_q.valid && !rd_src_q.is_dma;
  assign dma_rvalid_o   = rd_src_q.valid && rd_src_q.is_dma;
  assign lsu_rdata_lo_o = dccm_rd_data_lo_i;
  assign lsu_rdata_hi_o = dccm_rd_data_hi_i;
  assign dma_rdata_o    = dccm_rd_data_lo_i;
endmodule
